// File: rtl/imm_decode_stage.sv
// Pipelined immediate decoder: one instruction per handshake in, XLEN-wide extended immediate
// one cycle later, with a 2-entry main/skid buffer so in_ready comes straight from a flop.
module imm_decode_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_cmd,
   input  logic [2:0]       in_op_imm,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_op_imm,
   output logic [TAG_W-1:0] out_tag
);

   typedef enum logic [2:0] {
      FmtI    = 3'd0,
      FmtU    = 3'd1,
      FmtJ    = 3'd2,
      FmtS    = 3'd3,
      FmtB    = 3'd4,
      FmtZ    = 3'd5,
      FmtSh   = 3'd6,
      FmtRsvd = 3'd7
   } fmt_e;

   // ------------------------------------------------------------------
   // Combinational decode of the incoming instruction
   // ------------------------------------------------------------------
   fmt_e            fmt;
   logic [31:0]     imm32;
   logic [XLEN-1:0] dec_imm;
   logic            unused_opcode;

   assign fmt           = fmt_e'(in_op_imm);
   assign unused_opcode = ^in_cmd[6:0];

   // Z and SH are built zero-extended to 32 bits, so a uniform sign extension from bit 31
   // leaves them zero-extended to XLEN as well.
   always_comb begin
      imm32 = '0;
      unique case (fmt)
         FmtI, FmtRsvd: imm32 = {{20{in_cmd[31]}}, in_cmd[31:20]};
         FmtU:          imm32 = {in_cmd[31:12], 12'b0};
         FmtJ:          imm32 = {{12{in_cmd[31]}}, in_cmd[19:12], in_cmd[20], in_cmd[30:21],
                                 1'b0};
         FmtS:          imm32 = {{20{in_cmd[31]}}, in_cmd[31:25], in_cmd[11:7]};
         FmtB:          imm32 = {{20{in_cmd[31]}}, in_cmd[7], in_cmd[30:25], in_cmd[11:8],
                                 1'b0};
         FmtZ:          imm32 = {27'b0, in_cmd[19:15]};
         FmtSh: begin
            if (XLEN == 64) imm32 = {26'b0, in_cmd[25:20]};
            else            imm32 = {27'b0, in_cmd[24:20]};
         end
         default:       imm32 = '0;
      endcase
   end

   always_comb begin
      dec_imm       = {XLEN{imm32[31]}};
      dec_imm[31:0] = imm32;
   end

   // ------------------------------------------------------------------
   // Main / skid storage
   // ------------------------------------------------------------------
   logic             main_valid_q, main_valid_d;
   logic [XLEN-1:0]  main_imm_q, main_imm_d;
   logic [2:0]       main_op_q, main_op_d;
   logic [TAG_W-1:0] main_tag_q, main_tag_d;

   logic             skid_valid_q, skid_valid_d;
   logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
   logic [2:0]       skid_op_q, skid_op_d;
   logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

   logic accept;
   logic fire;

   assign in_ready   = ~skid_valid_q;
   assign out_valid  = main_valid_q;
   assign out_imm    = main_imm_q;
   assign out_op_imm = main_op_q;
   assign out_tag    = main_tag_q;

   assign accept = in_valid & ~skid_valid_q;
   assign fire   = main_valid_q & out_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      main_imm_d   = main_imm_q;
      main_op_d    = main_op_q;
      main_tag_d   = main_tag_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_op_d    = skid_op_q;
      skid_tag_d   = skid_tag_q;

      if (flush) begin
         // Data registers keep stale contents; only the valid bits matter.
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (fire && skid_valid_q) begin
         // in_ready is low here, so no accept can collide with the skid drain.
         main_valid_d = 1'b1;
         main_imm_d   = skid_imm_q;
         main_op_d    = skid_op_q;
         main_tag_d   = skid_tag_q;
         skid_valid_d = 1'b0;
      end else if (accept && (!main_valid_q || fire)) begin
         main_valid_d = 1'b1;
         main_imm_d   = dec_imm;
         main_op_d    = in_op_imm;
         main_tag_d   = in_tag;
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_imm_d   = dec_imm;
         skid_op_d    = in_op_imm;
         skid_tag_d   = in_tag;
      end else if (fire) begin
         main_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_imm_q   <= '0;
         main_op_q    <= '0;
         main_tag_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_imm_q   <= '0;
         skid_op_q    <= '0;
         skid_tag_q   <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_imm_q   <= main_imm_d;
         main_op_q    <= main_op_d;
         main_tag_q   <= main_tag_d;
         skid_valid_q <= skid_valid_d;
         skid_imm_q   <= skid_imm_d;
         skid_op_q    <= skid_op_d;
         skid_tag_q   <= skid_tag_d;
      end
   end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances share stimulus and are checked
// against a queue-based scoreboard of expected entries.
module tb_imm_decode_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_cmd, in_tag;
   logic [2:0]  in_op_imm;

   logic        in_ready32, out_valid32, in_ready64, out_valid64;
   logic [31:0] out_imm32, out_tag32, out_tag64;
   logic [63:0] out_imm64;
   logic [2:0]  out_op32, out_op64;

   always #5 clk = ~clk;

   imm_decode_stage #(.XLEN(32), .TAG_W(32)) dut32 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
      .in_cmd(in_cmd), .in_op_imm(in_op_imm), .in_tag(in_tag), .out_valid(out_valid32),
      .out_ready(out_ready), .out_imm(out_imm32), .out_op_imm(out_op32), .out_tag(out_tag32)
   );

   imm_decode_stage #(.XLEN(64), .TAG_W(32)) dut64 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
      .in_cmd(in_cmd), .in_op_imm(in_op_imm), .in_tag(in_tag), .out_valid(out_valid64),
      .out_ready(out_ready), .out_imm(out_imm64), .out_op_imm(out_op64), .out_tag(out_tag64)
   );

   typedef struct {
      logic [31:0] i32;
      logic [63:0] i64;
      logic [2:0]  op;
      logic [31:0] tag;
   } entry_t;

   entry_t q[$];
   entry_t cur;
   int     n_checks = 0;
   int     n_fail   = 0;
   bit     last_acc;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model_imm(input logic [31:0] c, input logic [2:0] op,
                                             input int xlen);
      longint v;
      case (op)
         3'd1:    v = longint'($signed({c[31:12], 12'b0}));
         3'd2:    v = longint'($signed({c[31], c[19:12], c[20], c[30:21], 1'b0}));
         3'd3:    v = longint'($signed({c[31:25], c[11:7]}));
         3'd4:    v = longint'($signed({c[31], c[7], c[30:25], c[11:8], 1'b0}));
         3'd5:    v = longint'({59'b0, c[19:15]});
         3'd6:    v = (xlen == 64) ? longint'({58'b0, c[25:20]}) : longint'({59'b0, c[24:20]});
         default: v = longint'($signed(c) >>> 20);
      endcase
      if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
      return v;
   endfunction

   task automatic set_in(input logic v, input logic [31:0] cmd, input logic [2:0] op,
                         input logic [31:0] tag, input logic [31:0] e32, input logic [63:0] e64);
      in_valid  = v;
      in_cmd    = cmd;
      in_op_imm = op;
      in_tag    = tag;
      cur.i32   = e32;
      cur.i64   = e64;
      cur.op    = op;
      cur.tag   = tag;
   endtask

   // Checks the current cycle against the scoreboard, updates it, then advances one clock.
   task automatic step();
      bit acc, fire;
      if (!rst) begin
         check_eq("in_ready32", in_ready32, q.size() < 2);
         check_eq("in_ready64", in_ready64, q.size() < 2);
         check_eq("out_valid32", out_valid32, q.size() > 0);
         check_eq("out_valid64", out_valid64, q.size() > 0);
         if (q.size() > 0) begin
            check_eq("imm32", out_imm32, q[0].i32);
            check_eq("imm64", out_imm64, q[0].i64);
            check_eq("op32", out_op32, q[0].op);
            check_eq("op64", out_op64, q[0].op);
            check_eq("tag32", out_tag32, q[0].tag);
            check_eq("tag64", out_tag64, q[0].tag);
         end
      end
      acc      = in_valid && (q.size() < 2);
      fire     = out_ready && (q.size() > 0);
      last_acc = acc && !rst && !flush;
      if (rst || flush) q.delete();
      else begin
         if (fire) void'(q.pop_front());
         if (acc)  q.push_back(cur);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   logic [31:0] vec_cmd[9];
   logic [2:0]  vec_op[9];
   logic [31:0] vec_e32[9];
   logic [63:0] vec_e64[9];

   initial begin
      vec_cmd = '{32'hFFF00093, 32'h12345037, 32'h0040006F, 32'hFE000C23, 32'hFE000EE3,
                  32'h80000037, 32'h03F09093, 32'h000FD073, 32'hFFF00093};
      vec_op  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd6, 3'd5, 3'd7};
      vec_e32 = '{32'hFFFFFFFF, 32'h12345000, 32'h00000004, 32'hFFFFFFF8, 32'hFFFFFFFC,
                  32'h80000000, 32'd31, 32'd31, 32'hFFFFFFFF};
      vec_e64 = '{64'hFFFFFFFFFFFFFFFF, 64'h12345000, 64'h4, 64'hFFFFFFFFFFFFFFF8,
                  64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000, 64'd63, 64'd31,
                  64'hFFFFFFFFFFFFFFFF};

      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      set_in(1'b0, '0, '0, '0, '0, '0);
      @(negedge clk);
      step();
      step();
      rst = 1'b0;
      check_eq("rst_imm32", out_imm32, 0);
      check_eq("rst_imm64", out_imm64, 0);
      check_eq("rst_tag", out_tag32, 0);
      check_eq("rst_op", out_op64, 0);
      idle(1);

      // Directed decode vectors, back to back
      for (int i = 0; i < 9; i++) begin
         set_in(1'b1, vec_cmd[i], vec_op[i], 32'h100 + i, vec_e32[i], vec_e64[i]);
         step();
      end
      idle(3);

      // Backpressure: tags 1 and 2 fill main and skid, tag 3 waits
      out_ready = 1'b0;
      set_in(1'b1, 32'h00100093, 3'd0, 32'd1, 32'd1, 64'd1); step();
      set_in(1'b1, 32'h00200093, 3'd0, 32'd2, 32'd2, 64'd2); step();
      set_in(1'b1, 32'h00300093, 3'd0, 32'd3, 32'd3, 64'd3);
      for (int i = 0; i < 3; i++) step();
      out_ready = 1'b1;
      last_acc  = 1'b0;
      for (int i = 0; i < 10 && !last_acc; i++) step();
      check_eq("tag3_accepted", last_acc, 1'b1);
      idle(4);

      // Flush with both entries full and a simultaneous offer
      out_ready = 1'b0;
      set_in(1'b1, 32'h00A00093, 3'd0, 32'hA, 32'd10, 64'd10); step();
      set_in(1'b1, 32'h00B00093, 3'd0, 32'hB, 32'd11, 64'd11); step();
      flush = 1'b1;
      set_in(1'b1, 32'h0BA00093, 3'd0, 32'hBAD, 32'hBA, 64'hBA); step();
      flush = 1'b0;
      out_ready = 1'b1;
      idle(3);

      // Reset mid-operation with both entries full
      out_ready = 1'b0;
      set_in(1'b1, 32'h00C00093, 3'd0, 32'hC, 32'd12, 64'd12); step();
      set_in(1'b1, 32'h00D00093, 3'd0, 32'hD, 32'd13, 64'd13); step();
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check_eq("mid_rst_imm32", out_imm32, 0);
      check_eq("mid_rst_imm64", out_imm64, 0);
      check_eq("mid_rst_tag", out_tag64, 0);
      check_eq("mid_rst_op", out_op32, 0);
      out_ready = 1'b1;
      idle(3);

      // Random stress
      for (int i = 0; i < 10000; i++) begin
         logic [31:0] c;
         logic [2:0]  op;
         c  = $urandom;
         op = 3'($urandom_range(0, 7));
         set_in($urandom_range(0, 9) < 7, c, op, $urandom, 32'(model_imm(c, op, 32)),
                model_imm(c, op, 64));
         out_ready = $urandom_range(0, 9) < 7;
         flush     = $urandom_range(0, 499) == 0;
         step();
      end
      flush = 1'b0;
      out_ready = 1'b1;
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Pipelined, parametrised immediate decoder for the NPC decode path, replacing the combinational immediate mux.
- Takes one instruction word per valid/ready handshake and produces the XLEN-wide extended immediate one cycle later.
- Adds XLEN generalisation, CSR zimm and shift-amount formats, a pass-through tag, flush, and a 2-entry skid buffer so in_ready is a registered signal.

Parameters:
- XLEN, 32, immediate output width; legal values are 32 and 64.
- TAG_W, 32, width of the opaque sideband tag (normally the PC) carried alongside the immediate.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  upstream has a valid instruction.
- in_ready  out  1  stage can accept; registered.
- in_cmd  in  32  instruction word.
- in_op_imm  in  3  format select: 0=I, 1=U, 2=J, 3=S, 4=B, 5=Z (CSR zimm), 6=SH (shamt), 7=reserved.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  out_imm, out_tag and out_op_imm are valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  decoded immediate.
- out_op_imm  out  3  copy of in_op_imm for the entry.
- out_tag  out  TAG_W  copy of in_tag for the entry.

Behaviour:
- Format rules. Sign bit is cmd[31] unless stated; sign-extend to XLEN.
- I: cmd[31:20].
- U: {cmd[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64.
- J: {cmd[31], cmd[19:12], cmd[20], cmd[30:21], 0}.
- S: {cmd[31:25], cmd[11:7]}.
- B: {cmd[31], cmd[7], cmd[30:25], cmd[11:8], 0}.
- Z: cmd[19:15], zero-extended.
- SH: cmd[24:20] when XLEN=32; cmd[25:20] when XLEN=64; zero-extended.
- Code 7 decodes as I.
- Storage: main register (drives the outputs) and skid register, each with its own valid bit. out_valid is the main valid bit; in_ready = !skid_valid.
- Events: accept = in_valid && in_ready; fire = out_valid && out_ready.
- Entry routing, in priority order:
  - rst: both valid bits 0; in_ready=1; out_imm, out_tag, out_op_imm = 0.
  - else flush: both valid bits 0 next cycle, and any accept in the same cycle is dropped. Data registers may keep stale values.
  - fire with skid full: skid moves to main; skid empties. No accept is possible, since in_ready=0.
  - accept when main is empty or firing: decoded entry loads main.
  - accept when main is full and not firing: decoded entry loads skid, so in_ready=0 next cycle.
  - fire with no accept and no skid: main empties.
- Latency: an entry accepted in cycle N appears on the outputs in cycle N+1. With out_ready held high, throughput is 1 per cycle.
- Main data registers change only when main is loaded. Outputs hold stable while out_valid && !out_ready.
- Ordering is strict FIFO; no entry is duplicated or lost except by flush or rst.
- Reset asserted mid-stream discards every entry, with no partial output.
- out_valid never depends combinationally on out_ready. in_ready never depends combinationally on any input.

Test Plan:
- Reset and basic decode, XLEN=32, out_ready=1: after rst, feed I 0xFFF00093, U 0x12345037, J 0x0040006F, S 0xFE000C23, B 0xFE000EE3 in back-to-back cycles -> outputs one cycle later, consecutively: 0xFFFFFFFF, 0x12345000, 0x00000004, 0xFFFFFFF8, 0xFFFFFFFC, each with its tag and op code.
- XLEN=64 extension: U 0x80000037 -> 0xFFFFFFFF80000000. SH 0x03F09093 -> 63 (XLEN=32 gives 31). Z 0x000FD073 -> 31. I 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF.
- Backpressure: out_ready=0 while 3 entries are offered with tags 1, 2, 3. Required: tag 1 held in main; tag 2 in skid; in_ready falls after the second accept; tag 3 waits. Then raise out_ready -> tags 1, 2, 3 delivered in order, each output stable while stalled.
- Flush: with main and skid both full, assert flush alongside an in_valid offer -> next cycle out_valid=0 and in_ready=1, and the offered entry never appears.
- Reset mid-operation: with both entries full, pulse rst for one cycle -> out_valid=0, in_ready=1, outputs zero, and no stale entry later emerges.
- Random stress: random in_valid and out_ready for 10k cycles against a reference model -> zero mismatches, no drops, no duplicates.
